// File: rtl/ooo_pkg.sv
// Shared types for the out-of-order integer back end.
// Holds the default data/tag widths, the decoded control bundle carried from
// decode to the ALU, the reservation-station entry layout and the CDB wakeup helper.
package ooo_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned TAG_W = 4;

  // ALU operation class: add, sub/compare, or decoded from funct3/funct7b5.
  typedef enum logic [1:0] {
    ALU_OP_ADD   = 2'b00,
    ALU_OP_SUB   = 2'b01,
    ALU_OP_FUNCT = 2'b10
  } alu_op_t;

  // Writeback source selection.
  typedef enum logic [1:0] {
    WD_ALU = 2'b00,
    WD_MEM = 2'b01,
    WD_PC4 = 2'b10
  } write_data_t;

  typedef struct packed {
    alu_op_t     alu_op;
    logic        alu_src_imm;
    logic        alu_src_pc;
    logic        branch;
    logic        jump;
    write_data_t write_data;
    logic        reg_write;
    logic [2:0]  funct3;
    logic        funct7b5;
  } ctrl_t;

  typedef struct packed {
    logic             ready;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  val;
  } src_t;

  typedef struct packed {
    ctrl_t            ctrl;
    logic [TAG_W-1:0] rob_tag;
    src_t             src1;
    src_t             src2;
    logic [XLEN-1:0]  imm;
    logic [XLEN-1:0]  pc;
  } rs_entry_t;

  // Capture a CDB broadcast into a waiting source; ready sources are left untouched.
  function automatic src_t wake_src(input src_t s, input logic cdb_valid,
                                    input logic [TAG_W-1:0] cdb_tag,
                                    input logic [XLEN-1:0] cdb_val);
    src_t r;
    r = s;
    if (!s.ready && cdb_valid && (s.tag == cdb_tag)) begin
      r.ready = 1'b1;
      r.val   = cdb_val;
    end
    return r;
  endfunction

endpackage

// File: rtl/reservation_station_select.sv
// Find-first-set over per-entry request bits; lowest index wins.
// Ports: req (per-entry ready), grant (one-hot), idx (binary index of grant),
// any (at least one request set).
module rs_select #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  output logic [N-1:0]     grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        idx      = IDX_W'(i);
        any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reservation_station.sv
// ALU reservation station: collapsing age-ordered queue (index 0 oldest) that
// captures operands from the CDB and issues the oldest entry with both sources ready.
// Ports: clk/reset (sync, active-high), flush; dispatch_* request/payload with
// dispatch_ready; cdb_* broadcast; issue_* payload with issue_valid/issue_ready;
// count of occupied entries.
module reservation_station
  import ooo_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = ooo_pkg::TAG_W,
  parameter int unsigned XLEN  = ooo_pkg::XLEN
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       dispatch_valid,
  output logic                       dispatch_ready,
  input  ctrl_t                      dispatch_ctrl,
  input  logic [TAG_W-1:0]           dispatch_rob_tag,
  input  logic                       dispatch_src1_ready,
  input  logic                       dispatch_src2_ready,
  input  logic [TAG_W-1:0]           dispatch_src1_tag,
  input  logic [TAG_W-1:0]           dispatch_src2_tag,
  input  logic [XLEN-1:0]            dispatch_src1_val,
  input  logic [XLEN-1:0]            dispatch_src2_val,
  input  logic [XLEN-1:0]            dispatch_imm,
  input  logic [XLEN-1:0]            dispatch_pc,
  input  logic                       cdb_valid,
  input  logic [TAG_W-1:0]           cdb_tag,
  input  logic [XLEN-1:0]            cdb_val,
  output logic                       issue_valid,
  input  logic                       issue_ready,
  output ctrl_t                      issue_ctrl,
  output logic [TAG_W-1:0]           issue_rob_tag,
  output logic [XLEN-1:0]            issue_src1,
  output logic [XLEN-1:0]            issue_src2,
  output logic [XLEN-1:0]            issue_imm,
  output logic [XLEN-1:0]            issue_pc,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  rs_entry_t        entries_q [DEPTH];
  rs_entry_t        entries_n [DEPTH];
  rs_entry_t        woken     [DEPTH];
  rs_entry_t        disp_entry;
  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_n;
  logic [CNT_W-1:0] base;
  logic [DEPTH-1:0] req;
  logic [DEPTH-1:0] grant;
  logic [IDX_W-1:0] sel_idx;
  logic             sel_any;
  logic             shift;
  logic             issue_fire;
  logic             dispatch_fire;

  // Selectable entries: occupied and both operands captured (registered state only).
  always_comb begin
    req = '0;
    for (int i = 0; i < DEPTH; i++) begin
      req[i] = (CNT_W'(i) < count_q) && entries_q[i].src1.ready && entries_q[i].src2.ready;
    end
  end

  rs_select #(
    .N     (DEPTH),
    .IDX_W (IDX_W)
  ) u_select (
    .req   (req),
    .grant (grant),
    .idx   (sel_idx),
    .any   (sel_any)
  );

  // Handshakes; reset behaves like flush and also closes dispatch.
  always_comb begin
    dispatch_ready = !reset && (count_q < CNT_W'(DEPTH));
    issue_valid    = !flush && !reset && sel_any;
    issue_fire     = issue_valid && issue_ready;
    dispatch_fire  = dispatch_valid && dispatch_ready && !flush;
  end

  // Issue payload straight from the selected entry.
  always_comb begin
    issue_ctrl    = entries_q[sel_idx].ctrl;
    issue_rob_tag = entries_q[sel_idx].rob_tag;
    issue_src1    = entries_q[sel_idx].src1.val;
    issue_src2    = entries_q[sel_idx].src2.val;
    issue_imm     = entries_q[sel_idx].imm;
    issue_pc      = entries_q[sel_idx].pc;
  end

  // Incoming entry, with same-cycle CDB bypass on its waiting sources.
  always_comb begin
    disp_entry            = '0;
    disp_entry.ctrl       = dispatch_ctrl;
    disp_entry.rob_tag    = dispatch_rob_tag;
    disp_entry.src1.ready = dispatch_src1_ready;
    disp_entry.src1.tag   = dispatch_src1_tag;
    disp_entry.src1.val   = dispatch_src1_val;
    disp_entry.src2.ready = dispatch_src2_ready;
    disp_entry.src2.tag   = dispatch_src2_tag;
    disp_entry.src2.val   = dispatch_src2_val;
    disp_entry.imm        = dispatch_imm;
    disp_entry.pc         = dispatch_pc;
    disp_entry.src1       = wake_src(disp_entry.src1, cdb_valid, cdb_tag, cdb_val);
    disp_entry.src2       = wake_src(disp_entry.src2, cdb_valid, cdb_tag, cdb_val);
  end

  // Wakeup is applied before the collapse so shifting entries keep their capture.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      woken[i]      = entries_q[i];
      woken[i].src1 = wake_src(entries_q[i].src1, cdb_valid, cdb_tag, cdb_val);
      woken[i].src2 = wake_src(entries_q[i].src2, cdb_valid, cdb_tag, cdb_val);
    end
  end

  // Collapse over the issued slot, then append the dispatch at the new tail.
  always_comb begin
    shift = 1'b0;
    for (int i = 0; i < DEPTH - 1; i++) begin
      shift        = shift | (issue_fire & grant[i]);
      entries_n[i] = shift ? woken[i+1] : woken[i];
    end
    entries_n[DEPTH-1] = woken[DEPTH-1];
    base = count_q - CNT_W'(issue_fire);
    if (dispatch_fire) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (CNT_W'(i) == base) begin
          entries_n[i] = disp_entry;
        end
      end
    end
    count_n = base + CNT_W'(dispatch_fire);
  end

  // Entry contents beyond count are don't-care, so only the count is cleared.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      count_q <= '0;
    end else begin
      count_q <= count_n;
    end
    for (int i = 0; i < DEPTH; i++) begin
      entries_q[i] <= entries_n[i];
    end
  end

  assign count = count_q;

endmodule
